// File: rtl/regfile_mp.sv
// Multi-port integer register file with a per-register pending-write scoreboard (x0 hardwired to 0).
// Optional write-through forwarding on the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [NUM_RD*AW-1:0]       i_rs_addr,
    output logic [NUM_RD*DATA_W-1:0]   o_rs_data,
    output logic [NUM_RD-1:0]          o_rs_busy,
    input  logic [NUM_WR-1:0]          i_rd_wren,
    input  logic [NUM_WR*AW-1:0]       i_rd_addr,
    input  logic [NUM_WR*DATA_W-1:0]   i_rd_data,
    input  logic                       i_alloc_en,
    input  logic [AW-1:0]              i_alloc_addr,
    output logic [NUM_REGS-1:0]        o_busy_vec
);

    // There is no handshake anywhere: every write and allocation presented
    // on a rising edge completes on that edge.
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [AW-1:0]       ra;
    logic [AW-1:0]       wa;

    // Later non-blocking assignments win: the highest write port beats lower
    // ones, and an allocation beats a write that would clear the same busy bit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (i_rd_wren[w] && (i_rd_addr[w*AW +: AW] != '0)) begin
                    regs[i_rd_addr[w*AW +: AW]] <= i_rd_data[w*DATA_W +: DATA_W];
                    busy[i_rd_addr[w*AW +: AW]] <= 1'b0;
                end
            end
            if (i_alloc_en && (i_alloc_addr != '0)) begin
                busy[i_alloc_addr] <= 1'b1;
            end
            busy[0] <= 1'b0;
        end
    end

    always_comb begin
        o_rs_data = '0;
        o_rs_busy = '0;
        ra        = '0;
        wa        = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = i_rs_addr[k*AW +: AW];
            if (ra != '0) begin
                o_rs_data[k*DATA_W +: DATA_W] = regs[ra];
                o_rs_busy[k]                  = busy[ra];
`ifdef REGFILE_BYPASS_EN
                // Ascending scan so the highest matching write port is forwarded.
                for (int w = 0; w < NUM_WR; w++) begin
                    wa = i_rd_addr[w*AW +: AW];
                    if (i_rd_wren[w] && (wa == ra)) begin
                        o_rs_data[k*DATA_W +: DATA_W] = i_rd_data[w*DATA_W +: DATA_W];
                        o_rs_busy[k] = i_alloc_en && (i_alloc_addr == ra);
                    end
                end
`endif
            end
        end
    end

    assign o_busy_vec = busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (2 read ports, 2 write ports): directed sequences,
// a constant-expectation vector table and randomized traffic against a reference model.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   ra [2];
    logic [AW-1:0]   wa [2];
    logic [DW-1:0]   wd [2];
    logic [1:0]      wren;
    logic            al_en;
    logic [AW-1:0]   al_a;

    logic [2*AW-1:0] rs_addr;
    logic [2*DW-1:0] rs_data;
    logic [1:0]      rs_busy;
    logic [2*AW-1:0] rd_addr;
    logic [2*DW-1:0] rd_data;
    logic [NR-1:0]   busy_vec;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] m_regs [NR];
    logic          m_busy [NR];

    assign rs_addr = {ra[1], ra[0]};
    assign rd_addr = {wa[1], wa[0]};
    assign rd_data = {wd[1], wd[0]};

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(2), .NUM_WR(2)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_rs_addr   (rs_addr),
        .o_rs_data   (rs_data),
        .o_rs_busy   (rs_busy),
        .i_rd_wren   (wren),
        .i_rd_addr   (rd_addr),
        .i_rd_data   (rd_data),
        .i_alloc_en  (al_en),
        .i_alloc_addr(al_a),
        .o_busy_vec  (busy_vec)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Architectural update rules: reset clears all; writes land in port order
    // (so the last port wins); an allocation is the newest producer.
    task automatic model_step();
        if (rst) begin
            for (int r = 0; r < NR; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            for (int w = 0; w < 2; w++) begin
                if (wren[w] && wa[w] != 0) begin
                    m_regs[wa[w]] = wd[w];
                    m_busy[wa[w]] = 1'b0;
                end
            end
            if (al_en && al_a != 0) m_busy[al_a] = 1'b1;
        end
    endtask

    // One clock: model absorbs the inputs present at the edge, then return #1 after it.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; wren = 2'b00; al_en = 1'b0; al_a = '0;
        wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0;
    endtask

    // Compare the combinational outputs with what the model predicts for the current inputs.
    task automatic check_model(input string nm);
        logic [DW-1:0] ed;
        logic          eb;
        logic [NR-1:0] ev;
        #1;
        for (int k = 0; k < 2; k++) begin
            ed = (ra[k] == 0) ? '0 : m_regs[ra[k]];
            eb = (ra[k] == 0) ? 1'b0 : m_busy[ra[k]];
`ifdef REGFILE_BYPASS_EN
            for (int w = 1; w >= 0; w--) begin
                if (ra[k] != 0 && wren[w] && wa[w] == ra[k]) begin
                    ed = wd[w];
                    eb = al_en && (al_a == ra[k]);
                    break;
                end
            end
`endif
            chk($sformatf("%s data%0d", nm, k), rs_data[k*DW +: DW], ed);
            chk($sformatf("%s busy%0d", nm, k), {31'b0, rs_busy[k]}, {31'b0, eb});
        end
        for (int r = 0; r < NR; r++) ev[r] = m_busy[r];
        chk($sformatf("%s busy_vec", nm), busy_vec, ev);
    endtask

    typedef struct {
        logic          rst;
        logic [1:0]    wren;
        logic [AW-1:0] wa0;
        logic [DW-1:0] wd0;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic          al_en;
        logic [AW-1:0] al_a;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        logic [1:0]    eb;
        logic [NR-1:0] evec;
    } vec_t;

    vec_t vt [10];

    initial begin
        // Expected values are those read back the cycle after each vector, with writes idle.
        vt[0] = '{1'b1, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 5'd3,  5'd4,  32'h0,    32'h0,    2'b00, 32'h0};
        vt[1] = '{1'b0, 2'b01, 5'd3, 32'h55,       5'd0, 32'h0,        1'b1, 5'd4, 5'd3,  5'd4,  32'h55,   32'h0,    2'b10, 32'h10};
        vt[2] = '{1'b1, 2'b01, 5'd3, 32'h99,       5'd0, 32'h0,        1'b1, 5'd4, 5'd3,  5'd4,  32'h0,    32'h0,    2'b00, 32'h0};
        vt[3] = '{1'b0, 2'b11, 5'd0, 32'hDEADBEEF, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0,  5'd0,  32'h0,    32'h0,    2'b00, 32'h0};
        vt[4] = '{1'b0, 2'b11, 5'd5, 32'h1111,     5'd5, 32'h2222,     1'b0, 5'd0, 5'd5,  5'd5,  32'h2222, 32'h2222, 2'b00, 32'h0};
        vt[5] = '{1'b0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b1, 5'd7, 5'd7,  5'd5,  32'h0,    32'h2222, 2'b01, 32'h80};
        vt[6] = '{1'b0, 2'b01, 5'd7, 32'h77,       5'd0, 32'h0,        1'b1, 5'd7, 5'd7,  5'd7,  32'h77,   32'h77,   2'b11, 32'h80};
        vt[7] = '{1'b0, 2'b10, 5'd0, 32'h0,        5'd7, 32'h88,       1'b0, 5'd0, 5'd7,  5'd0,  32'h88,   32'h0,    2'b00, 32'h0};
        vt[8] = '{1'b0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b1, 5'd0, 5'd0,  5'd7,  32'h0,    32'h88,   2'b00, 32'h0};
        vt[9] = '{1'b0, 2'b10, 5'd0, 32'h0,        5'd10, 32'h1234,    1'b1, 5'd9, 5'd9,  5'd10, 32'h0,    32'h1234, 2'b01, 32'h200};

        idle_inputs();
        ra[0] = '0; ra[1] = '0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_model("reset");
        chk("reset busy_vec const", busy_vec, '0);

        // T1: fill x1..x31 through port 0, then read back everything on both ports.
        for (int r = 1; r < NR; r++) begin
            wren = 2'b01; wa[0] = AW'(r); wd[0] = 32'hA5A5_0000 + r;
            cycle();
        end
        idle_inputs();
        for (int r = 0; r < NR; r++) begin
            ra[0] = AW'(r); ra[1] = AW'(r);
            #1;
            chk($sformatf("T1 x%0d p0", r), rs_data[DW-1:0],  (r == 0) ? 32'h0 : 32'hA5A5_0000 + r);
            chk($sformatf("T1 x%0d p1", r), rs_data[2*DW-1:DW], (r == 0) ? 32'h0 : 32'hA5A5_0000 + r);
        end

        // T4: same-cycle read of a register being written.
        wren = 2'b01; wa[0] = 5'd10; wd[0] = 32'h0000_1234;
        cycle();
        wd[0] = 32'hFEEDF00D; ra[0] = 5'd10; ra[1] = 5'd10;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("T4 before edge", rs_data[DW-1:0], 32'hFEEDF00D);
`else
        chk("T4 before edge", rs_data[DW-1:0], 32'h0000_1234);
`endif
        cycle();
        idle_inputs();
        #1;
        chk("T4 after edge", rs_data[DW-1:0], 32'hFEEDF00D);
        chk("T4 after edge p1", rs_data[2*DW-1:DW], 32'hFEEDF00D);

        // Bypass busy handling: write hit alone vs write hit with same-cycle allocation.
        al_en = 1'b1; al_a = 5'd12;
        cycle();
        idle_inputs(); ra[0] = 5'd12; ra[1] = 5'd12;
        wren = 2'b10; wa[1] = 5'd12; wd[1] = 32'hC0DE;
        check_model("bypass busy plain");
        al_en = 1'b1; al_a = 5'd12;
        check_model("bypass busy alloc");
        cycle();
        idle_inputs();
        check_model("bypass busy after");

        // Table-driven directed vectors (T2, T3, T5, T6 and scoreboard corners).
        for (int i = 0; i < 10; i++) begin
            rst = vt[i].rst; wren = vt[i].wren; al_en = vt[i].al_en; al_a = vt[i].al_a;
            wa[0] = vt[i].wa0; wd[0] = vt[i].wd0; wa[1] = vt[i].wa1; wd[1] = vt[i].wd1;
            ra[0] = vt[i].ra0; ra[1] = vt[i].ra1;
            cycle();
            idle_inputs();
            #1;
            chk($sformatf("vec%0d data0", i), rs_data[DW-1:0], vt[i].e0);
            chk($sformatf("vec%0d data1", i), rs_data[2*DW-1:DW], vt[i].e1);
            chk($sformatf("vec%0d rs_busy", i), {30'b0, rs_busy}, {30'b0, vt[i].eb});
            chk($sformatf("vec%0d busy_vec", i), busy_vec, vt[i].evec);
        end

        // Randomized traffic on a narrow address range so ports collide often.
        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 49) == 0);
            wren  = 2'($urandom_range(0, 3));
            wa[0] = AW'($urandom_range(0, 7));
            wa[1] = AW'($urandom_range(0, 7));
            wd[0] = $urandom;
            wd[1] = $urandom;
            al_en = ($urandom_range(0, 2) == 0);
            al_a  = AW'($urandom_range(0, 7));
            ra[0] = AW'($urandom_range(0, 7));
            ra[1] = AW'($urandom_range(0, 7));
            check_model($sformatf("rand%0d", n));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
